axis_bram_line_adapter: RTL and testbench

- Parametrised successor of the AXI-S/BRAM adapter.
- Packs a slave AXI-Stream into wide BRAM lines (write mode), or unpacks BRAM lines onto a master AXI-Stream with TLAST (read mode).
- Adds over the previous generation:
  - generic word/line/address widths;
  - configurable BRAM read latency;
  - zero-padded partial-line flush on input TLAST;
  - done/busy/error status.
- Sits between the DMA streams and the wide line BRAM; one instance per BRAM.

---
 rtl/axis_bram_line_adapter_if.sv | 39 +++
 rtl/axis_bram_line_adapter.sv | 169 ++++++++++++++++
 tb/tb_axis_bram_line_adapter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_bram_line_adapter_if.sv
// Stream and BRAM bus bundle for axis_bram_line_adapter.
// Handshakes are strict valid/ready. A beat transfers on a rising edge where
// tvalid and tready are both high. While tvalid is high and tready is low,
// the sender holds tdata and tlast stable and keeps tvalid high.
interface axis_bram_line_adapter_if #(
    parameter int DATA_W = 32,
    parameter int LINE_W = 1152,
    parameter int ADDR_W = 12
) ();
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;

    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;

    logic              bram_en;
    logic              bram_wen;
    logic [ADDR_W-1:0] bram_addr;
    logic [LINE_W-1:0] bram_din;
    logic [LINE_W-1:0] bram_dout;

    // Adapter side
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, bram_dout,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               bram_en, bram_wen, bram_addr, bram_din
    );

    // Environment side: DMA streams and the line BRAM
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, bram_dout,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               bram_en, bram_wen, bram_addr, bram_din
    );
endinterface

// File: rtl/axis_bram_line_adapter.sv
// Packs a slave AXI-Stream into wide BRAM lines (cfg_rw=0) or unpacks BRAM
// lines onto a master AXI-Stream with TLAST (cfg_rw=1).
module axis_bram_line_adapter #(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 36,
    parameter int ADDR_W         = 12,
    parameter int BRAM_RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_rw,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [ADDR_W-1:0]   cfg_bound_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     line_cnt,
    output logic [2:0]          dbg_state,
    axis_bram_line_adapter_if.slave bus
);
    localparam int PTR_W = $clog2(WORDS_PER_LINE);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS_PER_LINE - 1);
    localparam logic [1:0] LAT_END = 2'(BRAM_RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_WRITE   = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_DRAIN   = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [WORDS_PER_LINE-1:0][DATA_W-1:0] buf_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] bound_q;
    logic [ADDR_W:0]   cnt_q;
    logic              err_q;
    logic              last_q;
    logic [1:0]        lat_q;
    logic              at_bound;

    assign at_bound  = (addr_q == bound_q);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign line_cnt  = cnt_q;
    assign dbg_state = state_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = buf_q;

    always_comb begin
        state_d           = state_q;
        bus.s_axis_tready = 1'b0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tlast  = 1'b0;
        bus.bram_en       = 1'b0;
        bus.bram_wen      = 1'b0;
        done              = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_bound_addr < cfg_base_addr) state_d = S_FIN;
                    else if (cfg_rw)                    state_d = S_RD_REQ;
                    else                                state_d = S_FILL;
                end
            end
            S_FILL: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid && (ptr_q == PTR_LAST || bus.s_axis_tlast))
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                bus.bram_en  = 1'b1;
                bus.bram_wen = 1'b1;
                state_d      = (last_q || at_bound) ? S_FIN : S_FILL;
            end
            S_RD_REQ: begin
                bus.bram_en = 1'b1;
                state_d     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == LAT_END) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tdata  = buf_q[ptr_q];
                bus.m_axis_tlast  = (ptr_q == PTR_LAST) && at_bound;
                if (bus.m_axis_tready && ptr_q == PTR_LAST)
                    state_d = at_bound ? S_FIN : S_RD_REQ;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            bound_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        bound_q <= cfg_bound_addr;
                        addr_q  <= cfg_base_addr;
                        cnt_q   <= '0;
                        err_q   <= (cfg_bound_addr < cfg_base_addr);
                        buf_q   <= '0;
                        ptr_q   <= '0;
                        last_q  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (bus.s_axis_tvalid) begin
                        buf_q[ptr_q] <= bus.s_axis_tdata;
                        ptr_q        <= ptr_q + 1'b1;
                        last_q       <= bus.s_axis_tlast;
                    end
                end
                S_WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    // addr stops at bound, so a line at the top address never wraps
                    if (!(last_q || at_bound)) begin
                        addr_q <= addr_q + 1'b1;
                        buf_q  <= '0;
                        ptr_q  <= '0;
                    end
                end
                S_RD_REQ: lat_q <= '0;
                S_RD_WAIT: begin
                    // One cycle beyond the BRAM latency registers the held read data
                    if (lat_q == LAT_END) begin
                        buf_q <= bus.bram_dout;
                        ptr_q <= '0;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.m_axis_tready) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == PTR_LAST) begin
                            cnt_q <= cnt_q + 1'b1;
                            if (!at_bound) addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_bram_line_adapter.sv
// Directed bench for axis_bram_line_adapter with 4-word lines, one instance
// per BRAM read latency (1 and 2).
module tb_axis_bram_line_adapter;
  localparam int DW = 32;
  localparam int WPL = 4;
  localparam int LW = DW * WPL;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic          cfg_start, cfg_rw, sel;
  logic [AW-1:0] cfg_base, cfg_bound;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, m_tready;

  logic          busy1, done1, err1, busy2, done2, err2;
  logic [AW:0]   lc1, lc2;
  logic [2:0]    dbg1, dbg2;
  logic [LW-1:0] dout1, dout2, st2;
  logic [LW-1:0] mem [16];

  axis_bram_line_adapter_if #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW)) bus1 ();
  axis_bram_line_adapter_if #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW)) bus2 ();

  assign bus1.s_axis_tdata  = s_tdata;
  assign bus1.s_axis_tvalid = s_tvalid;
  assign bus1.s_axis_tlast  = s_tlast;
  assign bus1.m_axis_tready = m_tready;
  assign bus1.bram_dout     = dout1;
  assign bus2.s_axis_tdata  = s_tdata;
  assign bus2.s_axis_tvalid = s_tvalid;
  assign bus2.s_axis_tlast  = s_tlast;
  assign bus2.m_axis_tready = m_tready;
  assign bus2.bram_dout     = dout2;

  axis_bram_line_adapter #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .ADDR_W(AW), .BRAM_RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start & ~sel), .cfg_rw(cfg_rw),
    .cfg_base_addr(cfg_base), .cfg_bound_addr(cfg_bound),
    .busy(busy1), .done(done1), .err(err1), .line_cnt(lc1), .dbg_state(dbg1), .bus(bus1)
  );

  axis_bram_line_adapter #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .ADDR_W(AW), .BRAM_RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start & sel), .cfg_rw(cfg_rw),
    .cfg_base_addr(cfg_base), .cfg_bound_addr(cfg_bound),
    .busy(busy2), .done(done2), .err(err2), .line_cnt(lc2), .dbg_state(dbg2), .bus(bus2)
  );

  // BRAM read models: latency 1 and latency 2, output held between reads
  always @(posedge clk) begin
    if (bus1.bram_en && !bus1.bram_wen) dout1 <= mem[bus1.bram_addr[3:0]];
    if (bus2.bram_en && !bus2.bram_wen) st2 <= mem[bus2.bram_addr[3:0]];
    dout2 <= st2;
  end

  // Observed outputs of the selected instance
  logic          o_busy, o_done, o_err, o_en, o_wen, o_mvalid, o_mlast, o_stready;
  logic [DW-1:0] o_mdata;
  logic [AW-1:0] o_addr;
  logic [LW-1:0] o_din;
  logic [AW:0]   o_lc;
  logic [2:0]    o_dbg;
  assign o_busy    = sel ? busy2 : busy1;
  assign o_done    = sel ? done2 : done1;
  assign o_err     = sel ? err2 : err1;
  assign o_lc      = sel ? lc2 : lc1;
  assign o_dbg     = sel ? dbg2 : dbg1;
  assign o_en      = sel ? bus2.bram_en : bus1.bram_en;
  assign o_wen     = sel ? bus2.bram_wen : bus1.bram_wen;
  assign o_addr    = sel ? bus2.bram_addr : bus1.bram_addr;
  assign o_din     = sel ? bus2.bram_din : bus1.bram_din;
  assign o_mvalid  = sel ? bus2.m_axis_tvalid : bus1.m_axis_tvalid;
  assign o_mdata   = sel ? bus2.m_axis_tdata : bus1.m_axis_tdata;
  assign o_mlast   = sel ? bus2.m_axis_tlast : bus1.m_axis_tlast;
  assign o_stready = sel ? bus2.s_axis_tready : bus1.s_axis_tready;

  // ---------------- monitor (mid-cycle sampling) ----------------
  int n_en = 0, n_wen = 0, n_done = 0;
  int last_wen_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [LW-1:0] wr_data_q[$];
  logic [DW-1:0] beat_q[$];
  logic          beat_last_q[$];
  int            beat_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (o_en) n_en++;
      if (o_en && o_wen) begin
        n_wen++;
        wr_addr_q.push_back(o_addr);
        wr_data_q.push_back(o_din);
        last_wen_cyc = cyc;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cfg_start && !o_busy) start_cyc = cyc;
      if (o_mvalid && m_tready) begin
        beat_q.push_back(o_mdata);
        beat_last_q.push_back(o_mlast);
        beat_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- scoreboard / check ----------------
  int n_tests = 0, n_fail = 0;
  logic [LW-1:0] exp_q[$];
  int b_en, b_wen, b_done, b_wr, b_beat;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    b_en = n_en; b_wen = n_wen; b_done = n_done;
    b_wr = wr_data_q.size(); b_beat = beat_q.size();
  endtask

  task automatic start_xfer(input logic rw, input logic [AW-1:0] base, input logic [AW-1:0] bound);
    cfg_rw = rw; cfg_base = base; cfg_bound = bound; cfg_start = 1'b1;
    tick();
    // a second start with scrambled config while busy must be ignored
    cfg_rw = ~rw;
    cfg_base = AW'($urandom_range(0, 4095));
    cfg_bound = AW'($urandom_range(0, 4095));
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, output bit ok);
    ok = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ok = o_stready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit ok);
    bit ps;
    logic [DW-1:0] pd;
    logic pl;
    ok = 1'b0; ps = 1'b0; pd = '0; pl = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (ps) check("stall_hold", LW'({o_mvalid, o_mlast, o_mdata}), LW'({1'b1, pl, pd}));
      ps = o_mvalid && !m_tready; pd = o_mdata; pl = o_mlast;
      if (n_done > b_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (toggle) m_tready = ~m_tready;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;
    bit          rw;
    logic [AW-1:0] base;
    logic [AW-1:0] bound;
    int          nbeats;
    logic [DW-1:0] first;
    int          tlast_idx;
    bit          toggle;
    int          exp_acc;
    int          exp_lines;
    int          exp_en;
    bit          exp_err;
    int          exp_gap;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    bit ok;
    int acc, ref_cyc, nb;
    logic [LW-1:0] line;
    logic [LW-1:0] got;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 12'd5,    12'd6,    8, 32'h1,  7, 1'b0, 8, 2, 2, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b0, 12'd0,    12'd3,    6, 32'hA,  5, 1'b0, 6, 2, 2, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 12'd9,    12'd4,    0, 32'h0, -1, 1'b0, 0, 0, 0, 1'b1, 0};
    vecs[3] = '{1'b0, 1'b1, 12'd5,    12'd6,    0, 32'h0, -1, 1'b0, 0, 2, 2, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b1, 12'd5,    12'd6,    0, 32'h0, -1, 1'b0, 0, 2, 2, 1'b0, 4};
    vecs[5] = '{1'b0, 1'b1, 12'd5,    12'd6,    0, 32'h0, -1, 1'b1, 0, 2, 2, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b0, 12'd4095, 12'd4095, 6, 32'h21,-1, 1'b0, 4, 1, 1, 1'b0, 0};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[6] = {32'd8, 32'd7, 32'd6, 32'd5};

    cfg_start = 1'b0; cfg_rw = 1'b0; cfg_base = '0; cfg_bound = '0; sel = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", LW'(o_busy), LW'(0));
    check("rst_done", LW'(o_done), LW'(0));
    check("rst_err", LW'(o_err), LW'(0));
    check("rst_line_cnt", LW'(o_lc), LW'(0));
    check("rst_state", LW'(o_dbg), LW'(0));
    check("rst_bram", LW'({o_en, o_wen, o_addr}), LW'(0));
    check("rst_din", o_din, LW'(0));
    check("rst_axis", LW'({o_mvalid, o_mlast, o_mdata, o_stready}), LW'(0));
    rst = 1'b0;
    tick();

    for (int vi = 0; vi < 7; vi++) begin
      v = vecs[vi];
      sel = v.sel;
      m_tready = 1'b1;
      tick();
      snapshot();
      start_xfer(v.rw, v.base, v.bound);
      acc = 0;
      for (int b = 0; b < v.nbeats; b++) begin
        send_beat(v.first + DW'(b), (b == v.tlast_idx), ok);
        if (ok) acc++;
      end
      wait_done(300, v.toggle, ok);
      check($sformatf("v%0d_done_seen", vi), LW'(ok), LW'(1));
      tick();
      tick();
      m_tready = 1'b1;

      check($sformatf("v%0d_done_count", vi), LW'(n_done - b_done), LW'(1));
      check($sformatf("v%0d_idle", vi), LW'(o_busy), LW'(0));
      check($sformatf("v%0d_err", vi), LW'(o_err), LW'(v.exp_err));
      check($sformatf("v%0d_line_cnt", vi), LW'(o_lc), LW'(v.exp_lines));
      check($sformatf("v%0d_bram_en", vi), LW'(n_en - b_en), LW'(v.exp_en));

      if (!v.rw) begin
        check($sformatf("v%0d_accepted", vi), LW'(acc), LW'(v.exp_acc));
        check($sformatf("v%0d_wen_pulses", vi), LW'(n_wen - b_wen), LW'(v.exp_lines));
        for (int k = 0; k < v.exp_lines; k++) begin
          line = '0;
          for (int w = 0; w < WPL; w++)
            if (k * WPL + w < v.exp_acc) line[w*DW +: DW] = v.first + DW'(k * WPL + w);
          exp_q.push_back(line);
        end
        for (int k = 0; k < v.exp_lines; k++) begin
          line = exp_q.pop_front();
          if (b_wr + k < wr_data_q.size()) begin
            check($sformatf("v%0d_line%0d_data", vi, k), wr_data_q[b_wr + k], line);
            check($sformatf("v%0d_line%0d_addr", vi, k), LW'(wr_addr_q[b_wr + k]), LW'(v.base + AW'(k)));
          end else begin
            check($sformatf("v%0d_line%0d_missing", vi, k), LW'(0), LW'(1));
          end
        end
        ref_cyc = v.exp_err ? start_cyc : last_wen_cyc;
        check($sformatf("v%0d_done_timing", vi), LW'(done_cyc - ref_cyc), LW'(1));
        // a further beat after the transfer must not be accepted
        s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check($sformatf("v%0d_post_tready", vi), LW'(o_stready), LW'(0));
        tick();
        s_tvalid = 1'b0;
      end else begin
        nb = beat_q.size() - b_beat;
        check($sformatf("v%0d_beats", vi), LW'(nb), LW'(v.exp_lines * WPL));
        for (int k = 0; k < v.exp_lines; k++)
          for (int w = 0; w < WPL; w++) begin
            line = mem[(int'(v.base) + k) % 16];
            exp_q.push_back(LW'(line[w*DW +: DW]));
          end
        for (int j = 0; j < v.exp_lines * WPL; j++) begin
          line = exp_q.pop_front();
          if (j < nb) begin
            got = LW'({beat_last_q[b_beat + j], beat_q[b_beat + j]});
            check($sformatf("v%0d_beat%0d", vi, j), got,
                  LW'({(j == v.exp_lines * WPL - 1) ? 1'b1 : 1'b0, line[DW-1:0]}));
          end
        end
        if (nb > 0) begin
          ref_cyc = beat_cyc_q[b_beat + nb - 1];
          check($sformatf("v%0d_done_timing", vi), LW'(done_cyc - ref_cyc), LW'(1));
        end
        if (v.exp_gap > 0 && nb >= 5)
          check($sformatf("v%0d_line_gap", vi),
                LW'(beat_cyc_q[b_beat + 4] - beat_cyc_q[b_beat + 3] - 1), LW'(v.exp_gap));
      end
    end

    // reset in the middle of a read, just after the second beat
    sel = 1'b0;
    m_tready = 1'b1;
    snapshot();
    start_xfer(1'b1, 12'd5, 12'd6);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (beat_q.size() >= b_beat + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_rst_two_beats", LW'(ok), LW'(1));
    rst = 1'b1;
    m_tready = 1'b0;
    tick();
    check("mid_rst_busy", LW'(o_busy), LW'(0));
    check("mid_rst_state", LW'(o_dbg), LW'(0));
    check("mid_rst_axis", LW'({o_mvalid, o_mlast, o_mdata}), LW'(0));
    check("mid_rst_bram", LW'({o_en, o_wen, o_addr}), LW'(0));
    check("mid_rst_line_cnt", LW'(o_lc), LW'(0));
    rst = 1'b0;
    tick();
    tick();
    check("mid_rst_no_done", LW'(n_done - b_done), LW'(0));

    m_tready = 1'b1;
    snapshot();
    start_xfer(1'b1, 12'd5, 12'd6);
    wait_done(300, 1'b0, ok);
    check("restart_done_seen", LW'(ok), LW'(1));
    tick();
    check("restart_beats", LW'(beat_q.size() - b_beat), LW'(8));
    if (beat_q.size() > b_beat)
      check("restart_first_word", LW'(beat_q[b_beat]), LW'(1));
    check("restart_line_cnt", LW'(o_lc), LW'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
